quiz_round_controller: RTL and testbench

- Sequences a multi-player fastest-finger round. Sits between the synchronized buzzer inputs and the host/scoring logic.
- Runs an arming countdown with false-start lockout. Arbitrates the first press among eligible players, breaking same-cycle ties round-robin.
- Times the winner's answer window and applies the host's correct/wrong judgement. Re-opens the round to the remaining players after a wrong answer or timeout.

---
 rtl/quiz_round_controller.sv | 267 ++++++++++++++++++++++++++
 tb/tb_quiz_round_controller.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quiz_round_controller.sv
// -----------------------------------------------------------------------------
// quiz_round_controller
//
// Sequences one fastest-finger quiz round. The round runs through four steps:
// an arming countdown that locks out false starters, then arbitration of the
// first fresh buzzer press among eligible players, then a timed answer window
// for the winner, then the host's judgement. After a wrong answer or a
// timeout, the round re-opens to the players who are still eligible.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   buzzer          buzzer levels, already synchronised to clk
//   round_start     host pulse: start a round (honoured in IDLE and DONE)
//   round_abort     host pulse: abandon the round (highest priority)
//   judge_valid     host judgement strobe (honoured in ANSWER)
//   judge_correct   judgement value, qualified by judge_valid
//   state           0 IDLE, 1 COUNTDOWN, 2 ARMED, 3 ANSWER, 4 DONE
//   armed           high while state == ARMED
//   winner_onehot   player currently answering, or the player who won
//   winner_id       binary index of winner_onehot
//   lockout         players excluded from the rest of this round
//   answer_timer    remaining answer cycles
//   timeout_pulse   one cycle when the answer window expires unjudged
//   round_done      one cycle on entry to DONE
//   round_won       level in DONE: the round ended on a correct answer
//
// Every output comes straight from a register.
// -----------------------------------------------------------------------------
module quiz_round_controller #(
   parameter int N_PLAYERS     = 4,
   parameter int ARM_DELAY     = 16,
   parameter int ANSWER_CYCLES = 1000,
   parameter int TW            = 16,
   localparam int IDW          = $clog2(N_PLAYERS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_PLAYERS-1:0] buzzer,
   input  logic                 round_start,
   input  logic                 round_abort,
   input  logic                 judge_valid,
   input  logic                 judge_correct,
   output logic [2:0]           state,
   output logic                 armed,
   output logic [N_PLAYERS-1:0] winner_onehot,
   output logic [IDW-1:0]       winner_id,
   output logic [N_PLAYERS-1:0] lockout,
   output logic [TW-1:0]        answer_timer,
   output logic                 timeout_pulse,
   output logic                 round_done,
   output logic                 round_won
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_COUNTDOWN = 3'd1,
      S_ARMED     = 3'd2,
      S_ANSWER    = 3'd3,
      S_DONE      = 3'd4
   } state_t;

   // registered state
   state_t               r_state;
   logic                 r_armed;
   logic [N_PLAYERS-1:0] r_winner;
   logic [IDW-1:0]       r_winner_id;
   logic [N_PLAYERS-1:0] r_lockout;
   logic [TW-1:0]        r_count;
   logic [TW-1:0]        r_answer_timer;
   logic                 r_timeout;
   logic                 r_done;
   logic                 r_round_won;
   logic [N_PLAYERS-1:0] r_buzz_q;
   logic [IDW-1:0]       r_rr_ptr;

   // next-state values
   state_t               w_state_next;
   logic [N_PLAYERS-1:0] w_winner_next;
   logic [IDW-1:0]       w_winner_id_next;
   logic [N_PLAYERS-1:0] w_lockout_next;
   logic [TW-1:0]        w_count_next;
   logic [TW-1:0]        w_answer_next;
   logic                 w_timeout_next;
   logic                 w_done_next;
   logic                 w_round_won_next;
   logic [IDW-1:0]       w_rr_next;

   // press detection and arbitration
   logic [N_PLAYERS-1:0] w_press;
   logic [N_PLAYERS-1:0] w_cand;
   logic [N_PLAYERS-1:0] w_pick_onehot;
   logic [IDW-1:0]       w_pick_id;
   logic [IDW-1:0]       w_pick_succ;
   logic                 w_found;
   int                   w_idx;

   // Only a rising edge counts as a press; a held button never re-triggers.
   generate
      for (genvar gi = 0; gi < N_PLAYERS; gi++) begin : g_player
         assign w_press[gi]       = buzzer[gi] & ~r_buzz_q[gi];
         assign w_pick_onehot[gi] = w_found && (w_pick_id == IDW'(gi));
      end
   endgenerate

   assign w_cand = w_press & ~r_lockout;

   // Round-robin arbitration: scan cyclically from r_rr_ptr and take the
   // first eligible press.
   always_comb begin
      w_found   = 1'b0;
      w_pick_id = '0;
      w_idx     = 0;
      for (int k = 0; k < N_PLAYERS; k++) begin
         w_idx = int'(r_rr_ptr) + k;
         if (w_idx >= N_PLAYERS) begin
            w_idx = w_idx - N_PLAYERS;
         end
         if (!w_found && w_cand[IDW'(w_idx)]) begin
            w_found   = 1'b1;
            w_pick_id = IDW'(w_idx);
         end
      end
   end

   assign w_pick_succ = (w_pick_id == IDW'(N_PLAYERS - 1)) ? '0 : w_pick_id + IDW'(1);

   // next-state logic
   always_comb begin
      w_state_next     = r_state;
      w_winner_next    = r_winner;
      w_winner_id_next = r_winner_id;
      w_lockout_next   = r_lockout;
      w_count_next     = r_count;
      w_answer_next    = r_answer_timer;
      w_timeout_next   = 1'b0;
      w_done_next      = 1'b0;
      w_round_won_next = r_round_won;
      w_rr_next        = r_rr_ptr;

      if (round_abort) begin
         w_state_next     = S_IDLE;
         w_winner_next    = '0;
         w_winner_id_next = '0;
         w_lockout_next   = '0;
         w_count_next     = '0;
         w_answer_next    = '0;
         w_round_won_next = 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (round_start) begin
                  w_state_next   = S_COUNTDOWN;
                  w_lockout_next = '0;
                  w_count_next   = TW'(ARM_DELAY - 1);
               end
            end

            S_COUNTDOWN: begin
               // Any press before the buzzers go live is a false start.
               w_lockout_next = r_lockout | w_press;
               if (r_count == '0) begin
                  if (&w_lockout_next) begin
                     w_state_next     = S_DONE;
                     w_done_next      = 1'b1;
                     w_round_won_next = 1'b0;
                  end else begin
                     w_state_next = S_ARMED;
                  end
               end else begin
                  w_count_next = r_count - TW'(1);
               end
            end

            S_ARMED: begin
               if (w_found) begin
                  w_state_next     = S_ANSWER;
                  w_winner_next    = w_pick_onehot;
                  w_winner_id_next = w_pick_id;
                  w_answer_next    = TW'(ANSWER_CYCLES - 1);
                  w_rr_next        = w_pick_succ;
               end
            end

            S_ANSWER: begin
               if (judge_valid && judge_correct) begin
                  w_state_next     = S_DONE;
                  w_done_next      = 1'b1;
                  w_round_won_next = 1'b1;
               end else if (judge_valid || (r_answer_timer == '0)) begin
                  // A judgement in the expiry cycle takes precedence, so the
                  // timeout only fires when no judgement was given.
                  w_timeout_next   = ~judge_valid;
                  w_lockout_next   = r_lockout | r_winner;
                  w_winner_next    = '0;
                  w_winner_id_next = '0;
                  if (&w_lockout_next) begin
                     w_state_next     = S_DONE;
                     w_done_next      = 1'b1;
                     w_round_won_next = 1'b0;
                  end else begin
                     w_state_next = S_ARMED;
                  end
               end else begin
                  w_answer_next = r_answer_timer - TW'(1);
               end
            end

            S_DONE: begin
               if (round_start) begin
                  w_state_next     = S_COUNTDOWN;
                  w_lockout_next   = '0;
                  w_winner_next    = '0;
                  w_winner_id_next = '0;
                  w_round_won_next = 1'b0;
                  w_count_next     = TW'(ARM_DELAY - 1);
               end
            end

            default: begin
               w_state_next = S_IDLE;
            end
         endcase
      end
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_armed        <= 1'b0;
         r_winner       <= '0;
         r_winner_id    <= '0;
         r_lockout      <= '0;
         r_count        <= '0;
         r_answer_timer <= '0;
         r_timeout      <= 1'b0;
         r_done         <= 1'b0;
         r_round_won    <= 1'b0;
         r_buzz_q       <= '0;
         r_rr_ptr       <= '0;
      end else begin
         r_state        <= w_state_next;
         r_armed        <= (w_state_next == S_ARMED);
         r_winner       <= w_winner_next;
         r_winner_id    <= w_winner_id_next;
         r_lockout      <= w_lockout_next;
         r_count        <= w_count_next;
         r_answer_timer <= w_answer_next;
         r_timeout      <= w_timeout_next;
         r_done         <= w_done_next;
         r_round_won    <= w_round_won_next;
         r_buzz_q       <= buzzer;
         r_rr_ptr       <= w_rr_next;
      end
   end

   assign state         = r_state;
   assign armed         = r_armed;
   assign winner_onehot = r_winner;
   assign winner_id     = r_winner_id;
   assign lockout       = r_lockout;
   assign answer_timer  = r_answer_timer;
   assign timeout_pulse = r_timeout;
   assign round_done    = r_done;
   assign round_won     = r_round_won;

endmodule

// File: tb/tb_quiz_round_controller.sv
// -----------------------------------------------------------------------------
// tb_quiz_round_controller
//
// This bench drives quiz_round_controller with N=4, ARM_DELAY=4 and
// ANSWER_CYCLES=8. It runs directed scenarios first, then randomized rounds.
// A reference model checks the randomized rounds by tracking lockout and the
// round-robin pointer from the round rules.
// -----------------------------------------------------------------------------
module tb_quiz_round_controller;
   localparam int N  = 4;
   localparam int AD = 4;
   localparam int AC = 8;
   localparam int TW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  buzzer = '0;
   logic          round_start = 1'b0;
   logic          round_abort = 1'b0;
   logic          judge_valid = 1'b0;
   logic          judge_correct = 1'b0;
   logic [2:0]    state;
   logic          armed;
   logic [N-1:0]  winner_onehot;
   logic [1:0]    winner_id;
   logic [N-1:0]  lockout;
   logic [TW-1:0] answer_timer;
   logic          timeout_pulse;
   logic          round_done;
   logic          round_won;

   int n_pass  = 0;
   int n_total = 0;

   // model state
   logic [N-1:0] m_prev = '0;
   int           m_rr   = 0;
   logic [N-1:0] m_lock = '0;

   quiz_round_controller #(
      .N_PLAYERS(N), .ARM_DELAY(AD), .ANSWER_CYCLES(AC), .TW(TW)
   ) dut (
      .clk(clk), .rst(rst), .buzzer(buzzer), .round_start(round_start),
      .round_abort(round_abort), .judge_valid(judge_valid),
      .judge_correct(judge_correct), .state(state), .armed(armed),
      .winner_onehot(winner_onehot), .winner_id(winner_id), .lockout(lockout),
      .answer_timer(answer_timer), .timeout_pulse(timeout_pulse),
      .round_done(round_done), .round_won(round_won)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle of buzzer levels; p returns the fresh rising edges.
   task automatic cyc(input logic [N-1:0] b, output logic [N-1:0] p);
      buzzer = b;
      p      = b & ~m_prev;
      m_prev = b;
      tick();
   endtask

   // Round-robin winner: the candidate with the smallest cyclic distance from rr.
   function automatic int pick(input logic [N-1:0] c, input int rr);
      int best  = -1;
      int bestd = N;
      for (int i = 0; i < N; i++) begin
         if (c[i] && (((i - rr + N) % N) < bestd)) begin
            bestd = (i - rr + N) % N;
            best  = i;
         end
      end
      return best;
   endfunction

   task automatic do_reset;
      rst = 1'b1; buzzer = '0; round_start = 0; round_abort = 0;
      judge_valid = 0; judge_correct = 0;
      m_prev = '0; m_rr = 0; m_lock = '0;
      tick(); tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset;
      do_reset();
      n_total++;
      if ({state, armed, winner_onehot, winner_id, lockout, answer_timer,
           timeout_pulse, round_done, round_won} !== '0)
         $display("FAIL reset: state=%0d armed=%b oh=%b id=%0d lock=%b tmr=%0d to=%b done=%b won=%b, want all 0",
                  state, armed, winner_onehot, winner_id, lockout, answer_timer,
                  timeout_pulse, round_done, round_won);
      else n_pass++;
      $display("reset: outputs state=%0d lock=%b", state, lockout);
   endtask

   task automatic test_basic_win;
      logic [N-1:0] p;
      round_start = 1; tick(); round_start = 0;
      n_total++;
      if (state !== 3'd1 || armed !== 1'b0)
         $display("FAIL start_countdown: state=%0d armed=%b, want 1/0", state, armed);
      else n_pass++;
      repeat (AD - 1) tick();
      n_total++;
      if (state !== 3'd1) $display("FAIL countdown_len: state=%0d, want 1", state);
      else n_pass++;
      tick();
      n_total++;
      if (state !== 3'd2 || armed !== 1'b1)
         $display("FAIL armed_rise: state=%0d armed=%b, want 2/1", state, armed);
      else n_pass++;
      tick(); tick();
      cyc(4'b0100, p);
      n_total++;
      if (state !== 3'd3 || winner_onehot !== 4'b0100 || winner_id !== 2'd2 ||
          answer_timer !== 16'd7 || armed !== 1'b0)
         $display("FAIL basic_win: state=%0d oh=%b id=%0d tmr=%0d armed=%b, want 3/0100/2/7/0",
                  state, winner_onehot, winner_id, answer_timer, armed);
      else n_pass++;
      judge_valid = 1; judge_correct = 1; tick(); judge_valid = 0; judge_correct = 0;
      n_total++;
      if (state !== 3'd4 || round_won !== 1'b1 || round_done !== 1'b1 || winner_onehot !== 4'b0100)
         $display("FAIL basic_judge: state=%0d won=%b done=%b oh=%b, want 4/1/1/0100",
                  state, round_won, round_done, winner_onehot);
      else n_pass++;
      tick();
      n_total++;
      if (round_done !== 1'b0 || state !== 3'd4 || round_won !== 1'b1)
         $display("FAIL done_pulse: done=%b state=%0d won=%b, want 0/4/1", round_done, state, round_won);
      else n_pass++;
      cyc('0, p);
      $display("basic: winner=%0d won=%b", winner_id, round_won);
   endtask

   task automatic test_false_start;
      logic [N-1:0] p;
      do_reset();
      round_start = 1; tick(); round_start = 0;
      cyc(4'b0010, p);
      cyc(4'b0000, p);
      repeat (AD - 2) tick();
      n_total++;
      if (state !== 3'd2 || lockout !== 4'b0010)
         $display("FAIL false_start_lock: state=%0d lock=%b, want 2/0010", state, lockout);
      else n_pass++;
      cyc(4'b1010, p);
      n_total++;
      if (state !== 3'd3 || winner_id !== 2'd3 || lockout !== 4'b0010)
         $display("FAIL locked_skip: state=%0d id=%0d lock=%b, want 3/3/0010", state, winner_id, lockout);
      else n_pass++;
      judge_valid = 1; judge_correct = 1; cyc('0, p); judge_valid = 0; judge_correct = 0;
      round_start = 1; tick(); round_start = 0;
      n_total++;
      if (state !== 3'd1 || lockout !== '0 || winner_onehot !== '0 || round_won !== 1'b0)
         $display("FAIL restart_clear: state=%0d lock=%b oh=%b won=%b, want 1/0000/0000/0",
                  state, lockout, winner_onehot, round_won);
      else n_pass++;
      repeat (AD) tick();
      cyc(4'b1001, p);
      n_total++;
      if (state !== 3'd3 || winner_id !== 2'd0)
         $display("FAIL rr_wrap: state=%0d id=%0d, want 3/0", state, winner_id);
      else n_pass++;
      judge_valid = 1; judge_correct = 1; cyc('0, p); judge_valid = 0; judge_correct = 0;
      $display("false_start: winners 3 then %0d", winner_id);
   endtask

   task automatic test_tie;
      logic [N-1:0] p;
      round_start = 1; tick(); round_start = 0;
      repeat (AD) tick();
      cyc(4'b0010, p);
      n_total++;
      if (winner_id !== 2'd1) $display("FAIL tie_setup: id=%0d, want 1", winner_id);
      else n_pass++;
      judge_valid = 1; judge_correct = 1; cyc('0, p); judge_valid = 0; judge_correct = 0;
      round_start = 1; tick(); round_start = 0;
      repeat (AD) tick();
      cyc(4'b1111, p);
      n_total++;
      if (state !== 3'd3 || winner_id !== 2'd2 || winner_onehot !== 4'b0100)
         $display("FAIL tie_rr: state=%0d id=%0d oh=%b, want 3/2/0100", state, winner_id, winner_onehot);
      else n_pass++;
      judge_valid = 1; judge_correct = 1; cyc('0, p); judge_valid = 0; judge_correct = 0;
      $display("tie: all pressed, winner=%0d", winner_id);
   endtask

   task automatic test_timeout;
      logic [N-1:0] p;
      logic [N-1:0] lk;
      lk = '0;
      round_start = 1; tick(); round_start = 0;
      repeat (AD) tick();
      n_total++;
      if (state !== 3'd2) $display("FAIL timeout_armed: state=%0d, want 2", state);
      else n_pass++;
      for (int it = 0; it < N; it++) begin
         int j;
         do j = $urandom_range(0, N - 1); while (lk[j]);
         cyc(N'(1) << j, p);
         n_total++;
         if (state !== 3'd3 || winner_id !== 2'(j))
            $display("FAIL timeout_win: state=%0d id=%0d, want 3/%0d", state, winner_id, j);
         else n_pass++;
         for (int k = 1; k < AC; k++) begin
            cyc('0, p);
            n_total++;
            if (state !== 3'd3 || answer_timer !== 16'(AC - 1 - k) || timeout_pulse !== 1'b0)
               $display("FAIL timer_count: state=%0d tmr=%0d to=%b, want 3/%0d/0",
                        state, answer_timer, timeout_pulse, AC - 1 - k);
            else n_pass++;
         end
         cyc('0, p);
         lk[j] = 1'b1;
         n_total++;
         if (timeout_pulse !== 1'b1 || lockout !== lk || winner_onehot !== '0 ||
             state !== ((&lk) ? 3'd4 : 3'd2) || round_done !== (&lk))
            $display("FAIL timeout_exp: to=%b lock=%b oh=%b state=%0d done=%b, want 1/%b/0000/%0d/%b",
                     timeout_pulse, lockout, winner_onehot, state, round_done,
                     lk, (&lk) ? 4 : 2, (&lk));
         else n_pass++;
         $display("timeout: player %0d timed out, lock=%b", j, lockout);
      end
      n_total++;
      if (round_won !== 1'b0) $display("FAIL all_locked_won: won=%b, want 0", round_won);
      else n_pass++;
      tick();
      n_total++;
      if (timeout_pulse !== 1'b0 || round_done !== 1'b0 || state !== 3'd4)
         $display("FAIL pulse_len: to=%b done=%b state=%0d, want 0/0/4", timeout_pulse, round_done, state);
      else n_pass++;
   endtask

   task automatic test_held_and_judge_zero;
      logic [N-1:0] p;
      cyc(4'b0001, p);
      round_start = 1; tick(); round_start = 0;
      repeat (AD) tick();
      repeat (3) tick();
      n_total++;
      if (state !== 3'd2 || lockout !== '0 || winner_onehot !== '0)
         $display("FAIL held_button: state=%0d lock=%b oh=%b, want 2/0000/0000", state, lockout, winner_onehot);
      else n_pass++;
      cyc(4'b0000, p);
      cyc(4'b0001, p);
      n_total++;
      if (state !== 3'd3 || winner_id !== 2'd0)
         $display("FAIL repress: state=%0d id=%0d, want 3/0", state, winner_id);
      else n_pass++;
      repeat (AC - 1) tick();
      n_total++;
      if (state !== 3'd3 || answer_timer !== 16'd0)
         $display("FAIL timer_zero: state=%0d tmr=%0d, want 3/0", state, answer_timer);
      else n_pass++;
      judge_valid = 1; judge_correct = 0; tick(); judge_valid = 0;
      n_total++;
      if (timeout_pulse !== 1'b0 || state !== 3'd2 || lockout !== 4'b0001 || winner_onehot !== '0)
         $display("FAIL judge_at_zero: to=%b state=%0d lock=%b oh=%b, want 0/2/0001/0000",
                  timeout_pulse, state, lockout, winner_onehot);
      else n_pass++;
      $display("judge_zero: wrong answer at expiry, lock=%b", lockout);
   endtask

   task automatic test_abort_and_rst;
      logic [N-1:0] p;
      cyc(4'b0000, p);
      cyc(4'b0100, p);
      n_total++;
      if (state !== 3'd3 || winner_id !== 2'd2)
         $display("FAIL abort_setup: state=%0d id=%0d, want 3/2", state, winner_id);
      else n_pass++;
      round_abort = 1; tick(); round_abort = 0;
      n_total++;
      if (state !== 3'd0 || winner_onehot !== '0 || lockout !== '0 || round_done !== 1'b0 ||
          round_won !== 1'b0 || armed !== 1'b0)
         $display("FAIL abort: state=%0d oh=%b lock=%b done=%b won=%b armed=%b, want 0/0000/0000/0/0/0",
                  state, winner_onehot, lockout, round_done, round_won, armed);
      else n_pass++;
      cyc(4'b0000, p);
      round_start = 1; tick(); round_start = 0;
      tick();
      n_total++;
      if (state !== 3'd1) $display("FAIL rst_setup: state=%0d, want 1", state);
      else n_pass++;
      rst = 1'b1;
      #1;
      n_total++;
      if ({state, armed, winner_onehot, winner_id, lockout, answer_timer,
           timeout_pulse, round_done, round_won} !== '0)
         $display("FAIL async_rst: state=%0d lock=%b oh=%b tmr=%0d, want all 0",
                  state, lockout, winner_onehot, answer_timer);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      m_prev = '0; m_rr = 0;
      tick();
      $display("abort_rst: state=%0d after reset", state);
   endtask

   task automatic test_random(input int rounds);
      logic [N-1:0] p, cand, b;
      int w, act, jt;
      bit finished;
      do_reset();
      for (int r = 0; r < rounds; r++) begin
         round_start = 1; tick(); round_start = 0;
         m_lock = '0;
         n_total++;
         if (state !== 3'd1) $display("FAIL rnd_start: state=%0d, want 1", state);
         else n_pass++;
         for (int c = 0; c < AD; c++) begin
            b = N'($urandom & $urandom & $urandom);
            cyc(b, p);
            m_lock |= p;
         end
         if (&m_lock) begin
            n_total++;
            if (state !== 3'd4 || round_won !== 1'b0 || round_done !== 1'b1 || lockout !== m_lock)
               $display("FAIL rnd_all_false: state=%0d won=%b done=%b lock=%b, want 4/0/1/%b",
                        state, round_won, round_done, lockout, m_lock);
            else n_pass++;
            $display("round %0d: all false starts", r);
            continue;
         end
         n_total++;
         if (state !== 3'd2 || lockout !== m_lock)
            $display("FAIL rnd_armed: state=%0d lock=%b, want 2/%b", state, lockout, m_lock);
         else n_pass++;
         finished = 0;
         for (int s = 0; s < 60 && !finished; s++) begin
            b = N'($urandom_range(0, 15));
            cyc(b, p);
            cand = p & ~m_lock;
            if (cand == '0) begin
               n_total++;
               if (state !== 3'd2) $display("FAIL rnd_idle_armed: state=%0d, want 2", state);
               else n_pass++;
               continue;
            end
            w = pick(cand, m_rr);
            m_rr = (w + 1) % N;
            n_total++;
            if (state !== 3'd3 || winner_id !== 2'(w) || winner_onehot !== (N'(1) << w) ||
                answer_timer !== 16'(AC - 1))
               $display("FAIL rnd_win: state=%0d id=%0d oh=%b tmr=%0d, want 3/%0d/%b/%0d",
                        state, winner_id, winner_onehot, answer_timer, w, N'(1) << w, AC - 1);
            else n_pass++;
            act = $urandom_range(0, 2);
            jt  = (act == 2) ? AC : $urandom_range(0, AC - 1);
            for (int k = 0; k < jt; k++) cyc(N'($urandom_range(0, 15)), p);
            if (act != 2) begin
               n_total++;
               if (state !== 3'd3 || answer_timer !== 16'(AC - 1 - jt))
                  $display("FAIL rnd_tmr: state=%0d tmr=%0d, want 3/%0d", state, answer_timer, AC - 1 - jt);
               else n_pass++;
               judge_valid = 1; judge_correct = (act == 0);
               cyc(N'($urandom_range(0, 15)), p);
               judge_valid = 0; judge_correct = 0;
            end
            if (act == 0) begin
               n_total++;
               if (state !== 3'd4 || round_won !== 1'b1 || round_done !== 1'b1 || winner_id !== 2'(w))
                  $display("FAIL rnd_correct: state=%0d won=%b done=%b id=%0d, want 4/1/1/%0d",
                           state, round_won, round_done, winner_id, w);
               else n_pass++;
               finished = 1;
            end else begin
               m_lock[w] = 1'b1;
               n_total++;
               if (timeout_pulse !== (act == 2) || lockout !== m_lock || winner_onehot !== '0 ||
                   state !== ((&m_lock) ? 3'd4 : 3'd2) || round_done !== (&m_lock))
                  $display("FAIL rnd_miss: to=%b lock=%b oh=%b state=%0d done=%b, want %b/%b/0000/%0d/%b",
                           timeout_pulse, lockout, winner_onehot, state, round_done,
                           (act == 2), m_lock, (&m_lock) ? 4 : 2, (&m_lock));
               else n_pass++;
               if (&m_lock) finished = 1;
            end
         end
         if (!finished) begin
            round_abort = 1; tick(); round_abort = 0;
            n_total++;
            if (state !== 3'd0) $display("FAIL rnd_abort: state=%0d, want 0", state);
            else n_pass++;
         end
         $display("round %0d: state=%0d won=%b lock=%b rr=%0d", r, state, round_won, lockout, m_rr);
      end
   endtask

   initial begin
      test_reset();
      test_basic_win();
      test_false_start();
      test_tie();
      test_timeout();
      test_held_and_judge_zero();
      test_abort_and_rst();
      test_random(30);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
